// File: rtl/tone_generator_pkg.sv
// Shared PSG definitions used by the tone channels and the PSG top.
//
// Contents:
//   TONE_W       width of a tone period register (and of the tone down-counter)
//   psg_reg_e    PSG register index map (tone period/attenuation pairs, noise)
//   reload_due   true when a tone counter has reached its reload point
package tone_generator_pkg;

    localparam int unsigned TONE_W = 10;

    // Register index map of the PSG register file.
    typedef enum logic [2:0] {
        T1_FREQ    = 3'd0,
        T1_ATTN    = 3'd1,
        T2_FREQ    = 3'd2,
        T2_ATTN    = 3'd3,
        T3_FREQ    = 3'd4,
        T3_ATTN    = 3'd5,
        NOISE_CTL  = 3'd6,
        NOISE_ATTN = 3'd7
    } psg_reg_e;

    // A counter at 0 or 1 reloads on the next enable tick. Treating 0 like 1
    // lets a zero reset value (or a zero left behind by freq == 0) toggle on
    // the very first tick without ever decrementing through zero.
    function automatic logic reload_due(input logic [TONE_W-1:0] cnt);
        return cnt <= TONE_W'(1);
    endfunction

endpackage

// File: rtl/tone_generator.sv
// Square-wave tone channel of the SN76489-compatible PSG.
//
// A 10-bit down-counter advances once per divide-by-16 enable tick. When it
// reaches its reload point the output flips and the counter is reloaded from
// freq, so a steady freq = N gives a square wave of period 2N ticks.
// freq = 0 forces the output high (DC level used for sample playback).
//
// Parameters:
//   COUNTER_INIT  reset value of the down-counter (0..1023); per-channel
//                 offsets keep the three channels out of phase after reset
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         synchronous active-high reset, overrides clk_div16_en
//   clk_div16_en  single-cycle tick enable; the only thing that advances state
//   freq          half-period in enable ticks, sampled only at reload
//   audio_out     registered square-wave output
module tone_generator
    import tone_generator_pkg::*;
#(
    parameter int unsigned COUNTER_INIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_div16_en,
    input  logic [TONE_W-1:0] freq,
    output logic              audio_out
);

    localparam logic [TONE_W-1:0] CounterInit = TONE_W'(COUNTER_INIT);

    logic [TONE_W-1:0] counter_q, counter_d;
    logic              audio_d;

    always_comb begin
        counter_d = counter_q;
        audio_d   = audio_out;
        if (clk_div16_en) begin
            if (freq == '0) begin
                // Park the counter at 0 so a later nonzero freq toggles on
                // its first tick, starting the wave from the high level.
                counter_d = '0;
                audio_d   = 1'b1;
            end else if (reload_due(counter_q)) begin
                // freq is only sampled here; a mid-half-period change waits
                // for this reload.
                counter_d = freq;
                audio_d   = ~audio_out;
            end else begin
                counter_d = counter_q - TONE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= CounterInit;
            audio_out <= 1'b0;
        end else begin
            counter_q <= counter_d;
            audio_out <= audio_d;
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [9:0] freq0;
    logic [9:0] freq1;
    logic       out0;
    logic       out1;

    int checks = 0;
    int failures = 0;

    tone_generator #(.COUNTER_INIT(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .clk_div16_en (en),
        .freq         (freq0),
        .audio_out    (out0)
    );

    tone_generator #(.COUNTER_INIT(313)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .clk_div16_en (en),
        .freq         (freq1),
        .audio_out    (out1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [9:0] freq;
        logic       exp_out;
        logic [9:0] exp_cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge with the current inputs, then settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int exp;
        int gaps[10];

        reset = 1'b1;
        en    = 1'b0;
        freq0 = 10'd5;
        freq1 = 10'd2;

        // rst, en, freq, expected audio_out, expected counter (after the edge)
        vecs[0]  = '{1'b1, 1'b1, 10'd5,    1'b0, 10'd0};
        vecs[1]  = '{1'b0, 1'b0, 10'd5,    1'b0, 10'd0};
        vecs[2]  = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd5};
        vecs[3]  = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd4};
        vecs[4]  = '{1'b0, 1'b0, 10'd5,    1'b1, 10'd4};
        vecs[5]  = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd3};
        vecs[6]  = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd2};
        vecs[7]  = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd1};
        vecs[8]  = '{1'b0, 1'b1, 10'd5,    1'b0, 10'd5};
        vecs[9]  = '{1'b0, 1'b1, 10'd0,    1'b1, 10'd0};
        vecs[10] = '{1'b0, 1'b1, 10'd0,    1'b1, 10'd0};
        vecs[11] = '{1'b0, 1'b0, 10'd3,    1'b1, 10'd0};
        vecs[12] = '{1'b0, 1'b1, 10'd3,    1'b0, 10'd3};
        vecs[13] = '{1'b0, 1'b1, 10'd1,    1'b0, 10'd2};
        vecs[14] = '{1'b0, 1'b1, 10'd1,    1'b0, 10'd1};
        vecs[15] = '{1'b0, 1'b1, 10'd1,    1'b1, 10'd1};
        vecs[16] = '{1'b0, 1'b1, 10'd1,    1'b0, 10'd1};
        vecs[17] = '{1'b0, 1'b1, 10'd1,    1'b1, 10'd1};
        vecs[18] = '{1'b1, 1'b1, 10'd1,    1'b0, 10'd0};
        vecs[19] = '{1'b0, 1'b1, 10'd1023, 1'b1, 10'd1023};
        vecs[20] = '{1'b0, 1'b1, 10'd1023, 1'b1, 10'd1022};

        for (int i = 0; i < 21; i++) begin
            reset = vecs[i].rst;
            en    = vecs[i].en;
            freq0 = vecs[i].freq;
            step();
            check($sformatf("vec%0d_audio", i), int'(out0), int'(vecs[i].exp_out));
            check($sformatf("vec%0d_counter", i), int'(dut0.counter_q), int'(vecs[i].exp_cnt));
        end

        // freq=5, one tick per 16 clks: toggles on ticks 1, 6, 11, 16.
        freq0 = 10'd5;
        do_reset();
        check("a_reset_audio", int'(out0), 0);
        for (int t = 1; t <= 16; t++) begin
            pulse();
            n = 1 + (t - 1) / 5;
            check($sformatf("a_tick%0d", t), int'(out0), n % 2);
            idle(15);
            check($sformatf("a_gap%0d", t), int'(out0), n % 2);
        end

        // freq=1, enable every clk: 1,0,1,0...
        freq0 = 10'd1;
        do_reset();
        en = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            check($sformatf("b_tick%0d", t), int'(out0), t % 2);
        end
        en = 1'b0;

        // freq=0 for 20 ticks, then freq=3: toggles at ticks 1, 4, 7, 10.
        freq0 = 10'd0;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            pulse();
            check($sformatf("c_dc_audio%0d", t), int'(out0), 1);
            check($sformatf("c_dc_counter%0d", t), int'(dut0.counter_q), 0);
            idle(2);
        end
        freq0 = 10'd3;
        for (int t = 1; t <= 10; t++) begin
            pulse();
            n = 1 + (t - 1) / 3;
            check($sformatf("c_tone_tick%0d", t), int'(out0), 1 ^ (n % 2));
            idle(1);
        end

        // COUNTER_INIT=313, freq=2: first toggle on tick 313, then every 2.
        freq1 = 10'd2;
        do_reset();
        check("d_reset_counter", int'(dut1.counter_q), 313);
        en = 1'b1;
        for (int t = 1; t <= 320; t++) begin
            step();
            exp = (t < 313) ? 0 : ((1 + (t - 313) / 2) % 2);
            check($sformatf("d_tick%0d", t), int'(out1), exp);
        end
        en = 1'b0;

        // freq=10, changed to 4 mid-half-period: toggles at 1, 11, 15, 19.
        freq0 = 10'd10;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            pulse();
            if (t == 4) freq0 = 10'd4;
            n = int'(t >= 1) + int'(t >= 11) + int'(t >= 15) + int'(t >= 19);
            check($sformatf("e_tick%0d", t), int'(out0), n % 2);
            idle(3);
        end

        // Reset mid-half-period with enable high on the same edge.
        freq0 = 10'd5;
        do_reset();
        for (int t = 1; t <= 3; t++) pulse();
        check("f_pre_counter", int'(dut0.counter_q), 3);
        reset = 1'b1;
        en    = 1'b1;
        step();
        reset = 1'b0;
        en    = 1'b0;
        check("f_rst_audio", int'(out0), 0);
        check("f_rst_counter0", int'(dut0.counter_q), 0);
        check("f_rst_counter1", int'(dut1.counter_q), 313);

        // Irregular enable gaps (0 = back-to-back ticks): toggles at 1, 4, 7, 10.
        freq0 = 10'd3;
        gaps = '{0, 40, 7, 0, 23, 1, 15, 33, 0, 40};
        for (int t = 1; t <= 10; t++) begin
            pulse();
            n = 1 + (t - 1) / 3;
            check($sformatf("f_gap_tick%0d", t), int'(out0), n % 2);
            if (gaps[t - 1] == 0) begin
                // Next pulse() raises en again before the next edge.
            end else begin
                idle(gaps[t - 1]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
# tone_generator

Square-wave tone channel for the SN76489-compatible PSG. A 10-bit down-counter, advanced by the PSG's divide-by-16 clock enable, toggles a 1-bit output every `freq` enable ticks. Three instances sit inside the PSG top, one per tone channel:
- Their outputs feed the attenuation/mixer stage.
- Channel 2's output also clocks the noise shifter.

## Interface
Parameters:
- `COUNTER_INIT`, default 0: reset value of the down-counter, range 0..1023. Per-instance offsets (0, 313, 717) keep channels out of phase after reset.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: one clock; reset is synchronous and active-high.
- `clk_div16_en`, input, 1: single-cycle tick enable, one pulse per 16 `clk_en` cycles; the counter advances only on this.
- `freq`, input, 10: half-period in enable ticks (tone register value), sampled at reload.
- `audio_out`, output, 1: square-wave output, registered.

## Operation
- State:
  - `counter[9:0]`
  - `audio_out` register
- Reset (`reset`=1 at a rising edge):
  - `counter` <= `COUNTER_INIT`
  - `audio_out` <= 0
  - Reset overrides `clk_div16_en`.
- Cycle with `clk_div16_en`=0: all state holds.
- Cycle with `clk_div16_en`=1, `freq` != 0:
  - If `counter` <= 1: `counter` <= `freq`, `audio_out` <= ~`audio_out`.
  - Else: `counter` <= `counter` - 1.
- Cycle with `clk_div16_en`=1, `freq` == 0:
  - `audio_out` <= 1 (constant high, DC for sample playback).
  - `counter` <= 0.
- Result: with a steady `freq`=N (N>=1), `audio_out` toggles every N enable ticks; output period is 2N ticks, i.e. 32N `clk_en` cycles.
- `freq` is read only at reload. A change mid-half-period takes effect at the next toggle; the current half-period is not truncated.
- `freq`=1: toggles on every enable tick.
- Counter arithmetic is 10-bit unsigned and never decrements below 1, so there is no wrap-around.

## Timing
- `audio_out` changes on the same rising edge that samples `clk_div16_en`=1 with `counter` <= 1 (one-edge latency, no combinational path from inputs to output).
- First toggle after reset occurs on enable tick max(`COUNTER_INIT`,1). With `COUNTER_INIT`=0, the first enable tick toggles.
- Back-to-back enable pulses (every clk) are legal; behaviour depends only on the tick count.
- Reset asserted mid-half-period: the next edge restores reset values regardless of enable.
- `freq` transitioning from 0 to N: output starts at 1. The first enable with `counter`=0 toggles it to 0 and loads N.

## Structure
- Shared PSG package holds:
  - `TONE_W` = 10 (tone register width)
  - PSG register index constants: T1_FREQ=0, T1_ATTN=1, T2_FREQ=2, T2_ATTN=3, T3_FREQ=4, T3_ATTN=5, NOISE_CTL=6, NOISE_ATTN=7
- Single flat module; no sub-module.

## Test plan
- `COUNTER_INIT`=0, `freq`=5, enable every 16 clks: `audio_out` goes 0->1 on tick 1, then toggles on ticks 6, 11, 16 (period 10 ticks = 160 clks).
- `freq`=1, enable every clk: `audio_out` toggles every cycle: 1,0,1,0...
- `freq`=0 for 20 ticks: `audio_out`=1 throughout, `counter`=0. Then `freq`=3: toggles to 0 on next tick, then toggles every 3 ticks.
- `COUNTER_INIT`=313, `freq`=2: first toggle on tick 313, then every 2 ticks.
- `freq`=10; change to 4 after 3 ticks of a half-period: the current half-period still lasts 10 ticks, and subsequent half-periods last 4.
- `reset` pulsed mid-half-period with enable high on the same edge: `audio_out`=0, `counter`=`COUNTER_INIT` next cycle. Enable gaps of 0..40 clks do not alter the tick count between toggles.
